// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC, req/gnt/rvalid imem port, prefetch FIFO.
// Optional FETCH_ALIGN_CHK_EN: misaligned redirect targets raise a fetch exception.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_excp_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST    = PW'(FIFO_DEPTH - 1);

    logic [31:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [31:0]   pc_mem_q   [FIFO_DEPTH];
    logic [31:0]   inst_mem_q [FIFO_DEPTH];

    logic          redirect, misalign, halt, valid, pop, push, drop;
    logic          req, fire, excp_push, credit;
    logic [31:0]   raw_tgt, tgt;
    logic [CW:0]   used;
    logic [PW-1:0] w_idx;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign redirect = flush_i | branch_flag_i;
    assign raw_tgt  = flush_i ? flush_pc_i : branch_target_i;

`ifdef FETCH_ALIGN_CHK_EN
    logic halt_q;
    logic excp_mem_q [FIFO_DEPTH];

    assign tgt       = raw_tgt;
    assign misalign  = raw_tgt[1:0] != 2'b00;
    assign halt      = halt_q;
    assign if_excp_o = valid & excp_mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst)
            halt_q <= 1'b0;
        else if (redirect)
            halt_q <= misalign;
    end

    always_ff @(posedge clk) begin
        if (push | excp_push)
            excp_mem_q[w_idx] <= redirect;
    end
`else
    logic unused_tgt_lo;

    assign tgt           = {raw_tgt[31:2], 2'b00};
    assign misalign      = 1'b0;
    assign halt          = 1'b0;
    assign if_excp_o     = 1'b0;
    assign unused_tgt_lo = ^raw_tgt[1:0];
`endif

    // A word leaving the FIFO this cycle frees its slot for a new request.
    assign valid  = cnt_q != '0;
    assign pop    = valid & ~stall_i;
    assign used   = {1'b0, out_q} + {1'b0, cnt_q} - (CW + 1)'(pop);
    assign credit = used < DEPTH_W;

    assign req       = ~rst & ~redirect & ~halt & credit;
    assign fire      = req & imem_gnt_i;
    assign drop      = imem_rvalid_i & (drop_q != '0);
    assign push      = imem_rvalid_i & ~drop & ~redirect;
    assign excp_push = redirect & misalign;
    assign w_idx     = redirect ? '0 : wr_q;

    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        drop_d   = drop_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        out_d    = out_q + CW'(fire) - CW'(imem_rvalid_i);
        if (redirect) begin
            // Everything still in flight belongs to the old path.
            pc_d     = tgt;
            rsp_pc_d = tgt;
            drop_d   = out_q - CW'(imem_rvalid_i);
            rd_d     = '0;
            wr_d     = excp_push ? nxt('0) : '0;
            cnt_d    = CW'(excp_push);
        end else begin
            if (fire)
                pc_d = pc_q + 32'd4;
            if (drop)
                drop_d = drop_q - 1'b1;
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_d     = nxt(wr_q);
            end
            if (pop)
                rd_d = nxt(rd_q);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push | excp_push) begin
            pc_mem_q[w_idx]   <= redirect ? tgt : rsp_pc_q;
            inst_mem_q[w_idx] <= redirect ? 32'h0 : imem_rdata_i;
        end
    end

    assign imem_req_o  = req;
    assign imem_addr_o = pc_q;
    assign if_valid_o  = valid;
    assign if_pc_o     = valid ? pc_mem_q[rd_q] : 32'h0;
    assign if_inst_o   = valid ? inst_mem_q[rd_q] : 32'h0;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: vector table, directed corner sequences and
// randomized traffic against a stream-level reference model.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i, branch_flag_i;
    logic [31:0] flush_pc_i, branch_target_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        if_valid_o, if_excp_o;
    logic [31:0] if_pc_o, if_inst_o;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .flush_pc_i     (flush_pc_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .if_valid_o     (if_valid_o),
        .if_pc_o        (if_pc_o),
        .if_inst_o      (if_inst_o),
        .if_excp_o      (if_excp_o)
    );

    typedef struct {
        bit          st;
        bit          br;
        bit          fl;
        logic [31:0] bt;
        logic [31:0] ft;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [31:0] q_addr[$];
    int          q_age[$];
    int          gnt_pct, rv_pct, lat;

    bit          s_req, s_valid, s_excp, s_fire, s_pop;
    logic [31:0] s_addr, s_pc, s_inst;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input bit st, input bit br, input bit fl,
                                input bit e_req, input logic [31:0] e_addr,
                                input bit e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.st = st; v.br = br; v.fl = fl;
        v.bt = 32'h100; v.ft = 32'h180;
        v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // One clock period: drive at negedge, sample, advance the memory model.
    task automatic step(input bit st, input bit br, input bit fl,
                        input logic [31:0] bt, input logic [31:0] ft);
        stall_i = st; branch_flag_i = br; flush_i = fl;
        branch_target_i = bt; flush_pc_i = ft;
        imem_gnt_i = ($urandom_range(99) < gnt_pct);
        if (q_addr.size() > 0 && q_age[0] >= lat &&
            $urandom_range(99) < rv_pct) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = memw(q_addr[0]);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        #1;
        s_req = imem_req_o; s_addr = imem_addr_o;
        s_valid = if_valid_o; s_pc = if_pc_o;
        s_inst = if_inst_o; s_excp = if_excp_o;
        s_fire = imem_req_o && imem_gnt_i;
        s_pop = if_valid_o && !st;
        if (imem_rvalid_i) begin
            void'(q_addr.pop_front());
            void'(q_age.pop_front());
        end
        foreach (q_age[i]) q_age[i]++;
        if (s_fire) begin
            q_addr.push_back(imem_addr_o);
            q_age.push_back(1);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall_i = 0; flush_i = 0; branch_flag_i = 0;
        flush_pc_i = 0; branch_target_i = 0;
        imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        q_addr.delete(); q_age.delete();
        repeat (2) @(negedge clk);
        #1;
        chk1("rst req", imem_req_o, 1'b0);
        chk1("rst valid", if_valid_o, 1'b0);
        chk("rst pc", if_pc_o, 32'h0);
        chk("rst inst", if_inst_o, 32'h0);
        chk1("rst excp", if_excp_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Run until the first grant and first valid entry, checking both.
    task automatic expect_first(input string nm, input logic [31:0] a);
        bit seen_f = 0;
        bit seen_v = 0;
        for (int c = 0; c < 40 && !seen_v; c++) begin
            step(0, 0, 0, 0, 0);
            if (s_fire && !seen_f) begin
                seen_f = 1;
                chk({nm, " addr"}, s_addr, a);
            end
            if (s_valid) begin
                seen_v = 1;
                chk({nm, " pc"}, s_pc, a);
                chk({nm, " inst"}, s_inst, memw(a));
                chk1({nm, " excp"}, s_excp, 1'b0);
            end
        end
        if (!seen_v) begin
            tests++; fails++;
            $display("FAIL %s timeout: got no valid entry, expected pc %h", nm, a);
        end
    endtask

    vec_t vt[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_out, exp_fetch, bt, ft, fa[2];
        int npop, nf, r;
        bit st, br, fl;

        vt[0]  = mk(0, 0, 0, 1, 32'h00, 0, 32'h0);
        vt[1]  = mk(0, 0, 0, 1, 32'h04, 0, 32'h0);
        vt[2]  = mk(0, 0, 0, 1, 32'h08, 1, 32'h0);
        vt[3]  = mk(0, 0, 0, 1, 32'h0C, 1, 32'h4);
        vt[4]  = mk(1, 0, 0, 0, 32'h00, 1, 32'h8);
        vt[5]  = mk(1, 0, 0, 0, 32'h00, 1, 32'h8);
        vt[6]  = mk(1, 0, 0, 0, 32'h00, 1, 32'h8);
        vt[7]  = mk(1, 0, 0, 0, 32'h00, 1, 32'h8);
        vt[8]  = mk(1, 0, 0, 0, 32'h00, 1, 32'h8);
        vt[9]  = mk(0, 0, 0, 1, 32'h10, 1, 32'h8);
        vt[10] = mk(0, 0, 0, 1, 32'h14, 1, 32'hC);
        vt[11] = mk(0, 1, 1, 0, 32'h00, 1, 32'h10);
        vt[12] = mk(0, 0, 0, 1, 32'h180, 0, 32'h0);
        vt[13] = mk(0, 0, 0, 1, 32'h184, 0, 32'h0);
        vt[14] = mk(0, 0, 0, 1, 32'h188, 1, 32'h180);

        gnt_pct = 100; rv_pct = 100; lat = 1;
        do_reset();
        foreach (vt[i]) begin
            step(vt[i].st, vt[i].br, vt[i].fl, vt[i].bt, vt[i].ft);
            chk1($sformatf("vec%0d req", i), s_req, vt[i].e_req);
            if (vt[i].e_req)
                chk($sformatf("vec%0d addr", i), s_addr, vt[i].e_addr);
            chk1($sformatf("vec%0d valid", i), s_valid, vt[i].e_valid);
            chk($sformatf("vec%0d pc", i), s_pc,
                vt[i].e_valid ? vt[i].e_pc : 32'h0);
            chk($sformatf("vec%0d inst", i), s_inst,
                vt[i].e_valid ? memw(vt[i].e_pc) : 32'h0);
        end

        // Branch with two words still in flight.
        lat = 3;
        do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk1("inflight 2nd fire", s_fire, 1'b1);
        step(0, 1, 0, 32'h100, 0);
        chk1("inflight redirect req", s_req, 1'b0);
        expect_first("inflight branch", 32'h100);

        // PC wraps past the top of the address space.
        lat = 1;
        do_reset();
        step(0, 1, 0, 32'hFFFF_FFFC, 0);
        nf = 0;
        for (int c = 0; c < 20 && nf < 2; c++) begin
            step(0, 0, 0, 0, 0);
            if (s_fire) begin
                fa[nf] = s_addr;
                nf++;
            end
        end
        chk("wrap fire count", nf, 2);
        chk("wrap addr0", fa[0], 32'hFFFF_FFFC);
        chk("wrap addr1", fa[1], 32'h0);

`ifdef FETCH_ALIGN_CHK_EN
        do_reset();
        step(0, 1, 0, 32'h102, 0);
        step(1, 0, 0, 0, 0);
        chk1("align valid", s_valid, 1'b1);
        chk("align pc", s_pc, 32'h102);
        chk("align inst", s_inst, 32'h0);
        chk1("align excp", s_excp, 1'b1);
        chk1("align req", s_req, 1'b0);
        step(0, 0, 0, 0, 0);
        chk("align held pc", s_pc, 32'h102);
        for (int c = 0; c < 4; c++) begin
            step(0, 0, 0, 0, 0);
            chk1("align halt req", s_req, 1'b0);
            chk1("align halt valid", s_valid, 1'b0);
        end
        step(0, 0, 1, 0, 32'h180);
        expect_first("align resume", 32'h180);
`else
        do_reset();
        step(0, 1, 0, 32'h102, 0);
        expect_first("align masked", 32'h100);
`endif

        // Randomized traffic against the stream-level model.
        gnt_pct = 70; rv_pct = 60; lat = 1;
        do_reset();
        exp_out = 32'h0; exp_fetch = 32'h0; npop = 0;
        for (int c = 0; c < 3000; c++) begin
            st = ($urandom_range(99) < 30);
            r  = int'($urandom_range(99));
            br = (r < 4);
            fl = (r >= 2 && r < 6);
            bt = $urandom & 32'h0000_0FFC;
            ft = ($urandom & 32'h0000_0FFC) | 32'h1000;
            step(st, br, fl, bt, ft);
            if (s_req) chk("rnd addr", s_addr, exp_fetch);
            if (br || fl) chk1("rnd redirect req", s_req, 1'b0);
            if (s_valid) begin
                chk("rnd pc", s_pc, exp_out);
                chk("rnd inst", s_inst, memw(exp_out));
            end else begin
                chk("rnd bubble pc", s_pc, 32'h0);
                chk("rnd bubble inst", s_inst, 32'h0);
            end
            chk1("rnd excp", s_excp, 1'b0);
            if (br || fl) begin
                exp_fetch = fl ? ft : bt;
                exp_out   = exp_fetch;
            end else begin
                if (s_fire) exp_fetch += 32'd4;
                if (s_pop) exp_out += 32'd4;
            end
            if (s_pop) npop++;
        end
        chk1("rnd progress", npop >= 200, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
